s_uart_rx_param: RTL
====================

// Module: s_uart_rx_param
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8-bit, one-bit-per-clock receiver.
//  Adds: standard idle-high/start-low framing, clk-per-bit oversampling,
//  majority-vote mid-bit sampling, optional parity, 1/2 stop bits, and error flags.
//  Pairs with s_UART-class transmitters; output is consumed by a valid/ack handshake.
// PARAMETERS
//  DATA_BITS    8   data bits per frame, legal 5..9
//  CLKS_PER_BIT 16  clk cycles per bit period, even, >=4
//  PARITY       0   0 none, 1 odd, 2 even
//  STOP_BITS    1   1 or 2; only the first stop bit is checked
//  LSB_FIRST    1   1 LSB received first, 0 MSB first
// PORTS
//  clk        in  1          system clock, all logic on posedge
//  rst        in  1          synchronous reset, active-high
//  rxd        in  1          serial line, asynchronous, idle high
//  data       out DATA_BITS  last received word, stable while valid=1
//  valid      out 1          word available; held until ack
//  ack        in  1          consumer accepts word (sampled when valid=1)
//  parity_err out 1          parity mismatch on current word (0 if PARITY=0)
//  frame_err  out 1          first stop bit sampled 0 on current word
//  overrun    out 1          previous word was overwritten before ack
//  busy       out 1          1 in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, synchroniser flops preset to 1.
//  rxd passes a 2-flop synchroniser (2 cycles of latency); below, rxs = synchroniser output.
//  Bit timer: counts 0..CLKS_PER_BIT-1 and restarts at each bit boundary.
//   Bit value = majority of rxs at counts M-1, M, M+1, with M=CLKS_PER_BIT/2.
//  FSM:
//   IDLE:    rxs==0 -> START; timer cleared.
//   START:   at bit end, majority==1 -> IDLE (glitch, no flags); else -> DATA.
//   DATA:    shift DATA_BITS bits in LSB_FIRST order; after the last bit -> PARITY if PARITY!=0, else STOP.
//   PARITY:  compare received bit with odd/even parity of the data bits; -> STOP.
//   STOP:    after the first stop bit has been sampled (count M+1), publish; then
//            -> IDLE if bit==1, else -> BREAK; STOP_BITS=2 is not waited for.
//   BREAK:   wait for rxs==1 -> IDLE; no new frame starts while the line is held low.
//  Publish (registered, one cycle after the stop-bit vote):
//   data, parity_err and frame_err load together; valid<=1; overrun<=valid&~ack.
//   Latency, 8N1 with CLKS_PER_BIT=16: valid rises 155 clks after the first clk edge that samples rxd=0.
//  Handshake:
//   ack while valid=1, with no publish that cycle: valid, overrun, parity_err and frame_err all go to 0.
//   ack in the same cycle as a publish: the new word wins, valid stays 1 and overrun=0.
//   ack while valid=0 is ignored.
//  frame_err=1 still delivers the data word; errors never suppress valid.
//  Reset mid-frame: frame is abandoned and outputs go to reset values; the next start bit is received normally.
// TESTING (CLKS_PER_BIT=16, 8N1 unless stated)
//  1. Frame 0xA5, ack 3 clks after valid -> data=8'hA5, valid at +155 clks, flags 0, valid drops the clk after ack.
//  2. rxd low for 4 clks, then high -> no valid, busy returns to 0 within 16 clks, next frame 0x3C received correctly.
//  3. PARITY=2, word 0x07 with parity bit 0 -> parity_err=1; same word with parity bit 1 -> parity_err=0.
//  4. Frame 0x55 with stop bit 0, line held low 40 clks -> valid=1, frame_err=1, data=8'h55, no frame until rxd rises.
//  5. Frames 0x11 then 0x22, no ack -> data=8'h22, overrun=1; ack -> valid=0, overrun=0.
//  6. rst pulse during data bit 4 of 0xF0, then frame 0x81 -> all outputs 0 after rst, then data=8'h81 with flags 0.
//  7. DATA_BITS=7, LSB_FIRST=0, STOP_BITS=2, back-to-back frames 0x5A, 0x2B -> both received in order with flags 0.

Source files
------------

// File: rtl/s_uart_rx_param.sv
// -----------------------------------------------------------------------------
// s_uart_rx_param
// Parametrised UART receiver with idle-high / start-low framing, CLKS_PER_BIT
// oversampling and a 3-sample majority vote around the middle of each bit.
// Optional odd/even parity, one checked stop bit, error flags and a
// valid/ack output handshake.
//
// Parameters
//   DATA_BITS    data bits per frame (5..9)
//   CLKS_PER_BIT clk cycles per bit period (even, >= 4)
//   PARITY       0 none, 1 odd, 2 even
//   STOP_BITS    1 or 2 (only the first stop bit is checked, never waited for)
//   LSB_FIRST    1 LSB received first, 0 MSB first
//
// Ports
//   clk        system clock, everything on posedge
//   rst        synchronous reset, active-high
//   rxd        asynchronous serial input, idle high
//   data       last received word, stable while valid=1
//   valid      word available, held until ack
//   ack        consumer accepts word (only meaningful while valid=1)
//   parity_err parity mismatch on the current word
//   frame_err  first stop bit sampled low on the current word
//   overrun    previous word was overwritten before it was acked
//   busy       receiver FSM is not idle
// -----------------------------------------------------------------------------
module s_uart_rx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int M     = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(M + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    genvar gi;

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0 ||
            PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
            $error("s_uart_rx_param: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 start_bit_reg, start_bit_next;
    logic                 perr_pend_reg, perr_pend_next;
    logic [1:0]           sync_reg;
    logic                 samp_reg [2];

    logic                 rxs;
    logic                 maj;
    logic                 voted;
    logic                 bit_end;
    logic                 exp_par;
    logic                 publish;
    logic [DATA_BITS-1:0] shift_in;

    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 perr_reg;
    logic                 ferr_reg;
    logic                 ovr_reg;

    // Two-flop synchroniser, preset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rxd};
        end
    end

    assign rxs = sync_reg[1];

    // The first two vote samples are taken at counts M-1 and M; the third is
    // the live synchroniser output at count M+1, so the vote resolves on the
    // same cycle it is used. Outside active states the counter sits at 0,
    // which never matches M-1 >= 1.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_samp
            always_ff @(posedge clk) begin
                if (rst) begin
                    samp_reg[gi] <= 1'b1;
                end else if (cnt_reg == CNT_W'(M - 1 + gi)) begin
                    samp_reg[gi] <= rxs;
                end
            end
        end
    endgenerate

    assign maj = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rxs) | (samp_reg[1] & rxs);

    // For very short bit periods the vote count can coincide with the bit end,
    // so the start-bit decision takes the live vote when that happens.
    assign voted   = (cnt_reg == SAMP_C) ? maj : start_bit_reg;
    assign bit_end = (cnt_reg == CNT_LAST);

    // Even parity: parity bit equals XOR of data; odd parity: its complement.
    assign exp_par = (PARITY == 1) ? ~(^shift_reg) : (^shift_reg);

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            // New bit enters at the top; after DATA_BITS shifts the first bit is the LSB.
            assign shift_in = {maj, shift_reg[DATA_BITS-1:1]};
        end else begin : g_msb_first
            assign shift_in = {shift_reg[DATA_BITS-2:0], maj};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            start_bit_reg <= 1'b0;
            perr_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            start_bit_reg <= start_bit_next;
            perr_pend_reg <= perr_pend_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        shift_next     = shift_reg;
        start_bit_next = start_bit_reg;
        perr_pend_next = perr_pend_reg;
        publish        = 1'b0;

        if (state_reg != S_IDLE && state_reg != S_BREAK) begin
            cnt_next = bit_end ? '0 : cnt_reg + 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (!rxs) begin
                    // The detecting cycle counts as count 0 of the start bit.
                    state_next     = S_START;
                    cnt_next       = CNT_W'(1);
                    idx_next       = '0;
                    perr_pend_next = 1'b0;
                end
            end
            S_START: begin
                if (cnt_reg == SAMP_C) begin
                    start_bit_next = maj;
                end
                if (bit_end) begin
                    // A start bit that votes high was a glitch: drop it silently.
                    state_next = voted ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_reg == SAMP_C) begin
                    shift_next = shift_in;
                end
                if (bit_end) begin
                    if (idx_reg == IDX_LAST) begin
                        idx_next   = '0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (cnt_reg == SAMP_C) begin
                    perr_pend_next = maj ^ exp_par;
                end
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Publish as soon as the first stop bit is voted; a second stop
                // bit is just idle line as far as the receiver is concerned.
                if (cnt_reg == SAMP_C) begin
                    publish    = 1'b1;
                    cnt_next   = '0;
                    state_next = maj ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                cnt_next = '0;
                if (rxs) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output word and flags. A publish takes priority over an ack in the same
    // cycle, and the same-cycle ack keeps the new word from counting as overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            perr_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else if (publish) begin
            data_reg  <= shift_reg;
            valid_reg <= 1'b1;
            perr_reg  <= perr_pend_reg;
            ferr_reg  <= ~maj;
            ovr_reg   <= valid_reg & ~ack;
        end else if (valid_reg && ack) begin
            valid_reg <= 1'b0;
            perr_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end
    end

    assign data       = data_reg;
    assign valid      = valid_reg;
    assign parity_err = perr_reg;
    assign frame_err  = ferr_reg;
    assign overrun    = ovr_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule
